ysyx_22041461_pipe_ctrl: RTL and testbench
==========================================

YSYX_22041461_PIPE_CTRL -- requirements
Module: ysyx_22041461_pipe_ctrl

Interface
REQ-001 Port clk input 1: single clock; all state updates on posedge clk.
REQ-002 Port rst input 1: reset, asynchronous, active-low.
REQ-003 Port mem_busy input 1: MEM stage waiting on data memory.
REQ-004 Port ex_busy input 1: EX stage multi-cycle op (mul/div) not finished.
REQ-005 Port load_use input 1: ID instruction depends on load currently in EX.
REQ-006 Port redirect input 1: EX resolved taken branch/jump (PC redirect this cycle).
REQ-007 Port trap input 1: ecall/exception/mret committed in WB; pulse.
REQ-008 Ports IFreg_enable, IDreg_enable, EXreg_enable, MEMreg_enable, WBreg_enable output 1 each: per-stage pipeline-register update enables.
REQ-009 Ports IDreg_valid_fromCD, EXreg_valid_fromCD, MEMreg_valid_fromCD output 1 each: 0 inserts a bubble into that stage register on its next enabled edge.
REQ-010 Port flush output 1: active-low pipeline flush driven to every stage register's flush input.
REQ-011 Port stall_cnt output 64: performance counter of stalled cycles.

Function
REQ-012 State register, 3 states: RUN, REDIR, TRAP; plus 2-bit trap_cnt.
REQ-013 Enables/valids are combinational from current state and inputs; flush, state, trap_cnt, stall_cnt are registered.
REQ-014 In RUN, priority highest to lowest: trap, mem_busy, ex_busy, redirect, load_use, none.
REQ-015 trap=1 in RUN: next state TRAP, trap_cnt<=2, flush<=0 next edge; enables this cycle all 1; all valid_fromCD 0.
REQ-016 mem_busy=1 (no trap): all five enables 0; all valid_fromCD 1; state stays RUN.
REQ-017 ex_busy=1 (no trap/mem_busy): IF/ID/EX enables 0; MEM/WB enables 1; MEMreg_valid_fromCD 0; IDreg/EXreg_valid_fromCD 1.
REQ-018 redirect=1 (none higher): all enables 1; IDreg_valid_fromCD 0, EXreg_valid_fromCD 0, MEMreg_valid_fromCD 1; next state REDIR.
REQ-019 load_use=1 (none higher): IF/ID enables 0; EX/MEM/WB enables 1; EXreg_valid_fromCD 0; others 1.
REQ-020 No condition: all enables 1, all valid_fromCD 1, flush 1.
REQ-021 REDIR lasts exactly one cycle: IDreg_valid_fromCD 0 (kills in-flight wrong-path fetch), other outputs per REQ-016..020 evaluated ignoring redirect; return to RUN unless mem_busy/ex_busy, which hold REDIR until both clear.
REQ-022 redirect asserted while in REDIR is ignored.
REQ-023 TRAP: flush 0 while trap_cnt!=0, trap_cnt decrements each edge; flush returns to 1 on edge where trap_cnt reaches 0, state returns to RUN same edge; enables 1, valid_fromCD 0 throughout; all other inputs ignored.
REQ-024 trap asserted in REDIR: same as REQ-015 (trap preempts REDIR).
REQ-025 stall_cnt increments by 1 on each edge where any enable output is 0; saturates at all-ones, no wrap.
REQ-026 Simultaneous mem_busy and redirect: redirect is not consumed; upstream holds redirect until mem_busy clears.

Reset
REQ-027 rst=0 asynchronously forces state RUN, trap_cnt 0, flush 0, stall_cnt 0.
REQ-028 flush releases to 1 on the first posedge clk after rst rises.
REQ-029 While rst=0, all enables 1 and all valid_fromCD 0.
REQ-030 Reset asserted mid-TRAP or mid-REDIR aborts it; no residual bubble after release.

Verification
REQ-031 Reset: rst 0->1, no inputs -> flush 0 then 1 after one edge; enables 1, valids 1, stall_cnt 0.
REQ-032 load_use one cycle -> IF/ID enable 0, EXreg_valid_fromCD 0 that cycle; stall_cnt=1.
REQ-033 redirect pulse -> cycle0 ID/EX valid 0; cycle1 state REDIR, IDreg_valid_fromCD 0; cycle2 all valids 1.
REQ-034 mem_busy 3 cycles with ex_busy and load_use also 1 -> all enables 0 for 3 cycles; stall_cnt=3; then ex_busy behaviour.
REQ-035 trap pulse during ex_busy -> flush 0 for exactly 2 cycles, then 1; state RUN; no stall_cnt change.
REQ-036 stall_cnt preloaded near all-ones via force, stall held -> counter stops at 0xFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/ysyx_22041461_pipe_ctrl.sv
// Pipeline hazard controller: per-stage register enables, bubble injection,
// trap flush sequencing and a saturating stalled-cycle counter.
module ysyx_22041461_pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  input  logic        ex_busy,
  input  logic        load_use,
  input  logic        redirect,
  input  logic        trap,
  output logic        IFreg_enable,
  output logic        IDreg_enable,
  output logic        EXreg_enable,
  output logic        MEMreg_enable,
  output logic        WBreg_enable,
  output logic        IDreg_valid_fromCD,
  output logic        EXreg_valid_fromCD,
  output logic        MEMreg_valid_fromCD,
  output logic        flush,
  output logic [63:0] stall_cnt
);

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned TRAP_W = 2;
  localparam int unsigned EN_W   = 5;
  localparam int unsigned VLD_W  = 3;
  localparam logic [TRAP_W-1:0] TRAP_LEN = TRAP_W'(2);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_TRAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TRAP_W-1:0]  trap_cnt_q, trap_cnt_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [EN_W-1:0]    en_c;   // {IF, ID, EX, MEM, WB}
  logic [VLD_W-1:0]   vld_c;  // {ID, EX, MEM}
  logic               any_stall_c;

  // Hazard resolution and next-state logic
  always_comb begin
    en_c       = '1;
    vld_c      = '1;
    state_d    = state_q;
    trap_cnt_d = trap_cnt_q;
    flush_d    = 1'b1;
    unique case (state_q)
      S_TRAP: begin
        vld_c      = '0;
        trap_cnt_d = (trap_cnt_q == '0) ? '0 : trap_cnt_q - TRAP_W'(1);
        if (trap_cnt_d == '0) begin
          state_d = S_RUN;
        end else begin
          flush_d = 1'b0;
        end
      end
      S_RUN, S_REDIR: begin
        if (trap) begin
          vld_c      = '0;
          state_d    = S_TRAP;
          trap_cnt_d = TRAP_LEN;
          flush_d    = 1'b0;
        end else if (mem_busy) begin
          en_c = '0;
        end else if (ex_busy) begin
          en_c  = 5'b00011;
          vld_c = 3'b110;
        end else if (redirect && (state_q == S_RUN)) begin
          vld_c   = 3'b001;
          state_d = S_REDIR;
        end else if (load_use) begin
          en_c  = 5'b00111;
          vld_c = 3'b101;
        end
        // Wrong-path fetch still in flight is killed until REDIR retires
        if ((state_q == S_REDIR) && !trap) begin
          vld_c[2] = 1'b0;
          state_d  = (mem_busy || ex_busy) ? S_REDIR : S_RUN;
        end
      end
      default: begin
        state_d    = S_RUN;
        trap_cnt_d = '0;
      end
    endcase
    any_stall_c = ~(&en_c);
    stall_cnt_d = (any_stall_c && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                       : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      trap_cnt_q  <= '0;
      flush_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      trap_cnt_q  <= trap_cnt_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset overrides: stages keep clocking but only carry bubbles
  always_comb begin
    IFreg_enable        = en_c[4] | ~rst;
    IDreg_enable        = en_c[3] | ~rst;
    EXreg_enable        = en_c[2] | ~rst;
    MEMreg_enable       = en_c[1] | ~rst;
    WBreg_enable        = en_c[0] | ~rst;
    IDreg_valid_fromCD  = vld_c[2] & rst;
    EXreg_valid_fromCD  = vld_c[1] & rst;
    MEMreg_valid_fromCD = vld_c[0] & rst;
    flush               = flush_q;
    stall_cnt           = stall_cnt_q;
  end

endmodule

// File: tb/tb_ysyx_22041461_pipe_ctrl.sv
// Directed-vector bench for ysyx_22041461_pipe_ctrl with a queue scoreboard.
module tb_ysyx_22041461_pipe_ctrl;

  typedef struct packed {
    logic        rst;
    logic [4:0]  in;     // {trap, redirect, load_use, ex_busy, mem_busy}
    logic        pre;    // preload stall counter near saturation
    logic [4:0]  en;     // {IF, ID, EX, MEM, WB}
    logic [2:0]  vld;    // {ID, EX, MEM}
    logic        flush;
    logic [63:0] stall;
  } vec_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [4:0]  en;
    logic [2:0]  vld;
    logic        flush;
    logic [63:0] stall;
  } exp_t;

  localparam logic [63:0] PRELOAD = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] SAT     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_busy = 1'b0, ex_busy = 1'b0, load_use = 1'b0, redirect = 1'b0, trap = 1'b0;
  logic IFreg_enable, IDreg_enable, EXreg_enable, MEMreg_enable, WBreg_enable;
  logic IDreg_valid_fromCD, EXreg_valid_fromCD, MEMreg_valid_fromCD;
  logic flush;
  logic [63:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_22041461_pipe_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_busy            (mem_busy),
    .ex_busy             (ex_busy),
    .load_use            (load_use),
    .redirect            (redirect),
    .trap                (trap),
    .IFreg_enable        (IFreg_enable),
    .IDreg_enable        (IDreg_enable),
    .EXreg_enable        (EXreg_enable),
    .MEMreg_enable       (MEMreg_enable),
    .WBreg_enable        (WBreg_enable),
    .IDreg_valid_fromCD  (IDreg_valid_fromCD),
    .EXreg_valid_fromCD  (EXreg_valid_fromCD),
    .MEMreg_valid_fromCD (MEMreg_valid_fromCD),
    .flush               (flush),
    .stall_cnt           (stall_cnt)
  );

  function automatic void v(input logic r, input logic [4:0] in, input logic pre,
                            input logic [4:0] en, input logic [2:0] vld,
                            input logic fl, input logic [63:0] st);
    vec_t t;
    t.rst = r; t.in = in; t.pre = pre; t.en = en; t.vld = vld; t.flush = fl; t.stall = st;
    vq.push_back(t);
  endfunction

  // Monitor: compares every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    logic [4:0] a_en;
    logic [2:0] a_vld;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
        e     = sb.pop_front();
        a_en  = {IFreg_enable, IDreg_enable, EXreg_enable, MEMreg_enable, WBreg_enable};
        a_vld = {IDreg_valid_fromCD, EXreg_valid_fromCD, MEMreg_valid_fromCD};
        checks += 4;
        if (a_en !== e.en) begin
          errors++;
          $display("FAIL vec%0d enables: got %b want %b", e.idx, a_en, e.en);
        end
        if (a_vld !== e.vld) begin
          errors++;
          $display("FAIL vec%0d valids: got %b want %b", e.idx, a_vld, e.vld);
        end
        if (flush !== e.flush) begin
          errors++;
          $display("FAIL vec%0d flush: got %b want %b", e.idx, flush, e.flush);
        end
        if (stall_cnt !== e.stall) begin
          errors++;
          $display("FAIL vec%0d stall_cnt: got %h want %h", e.idx, stall_cnt, e.stall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: apply one vector per cycle at the falling edge
  initial begin
    vec_t t;
    exp_t e;
    logic forced;
    forced = 1'b0;
    // reset, release, load-use
    v(0, 5'b00000, 0, 5'b11111, 3'b000, 0, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 0, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd0);
    v(1, 5'b00100, 0, 5'b00111, 3'b101, 1, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd1);
    // redirect pulse, redirect ignored in REDIR
    v(1, 5'b01000, 0, 5'b11111, 3'b001, 1, 64'd1);
    v(1, 5'b00000, 0, 5'b11111, 3'b011, 1, 64'd1);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd1);
    v(1, 5'b01000, 0, 5'b11111, 3'b001, 1, 64'd1);
    v(1, 5'b01000, 0, 5'b11111, 3'b011, 1, 64'd1);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd1);
    // REDIR held by mem_busy then ex_busy
    v(1, 5'b01000, 0, 5'b11111, 3'b001, 1, 64'd1);
    v(1, 5'b00001, 0, 5'b00000, 3'b011, 1, 64'd1);
    v(1, 5'b00010, 0, 5'b00011, 3'b010, 1, 64'd2);
    v(1, 5'b00000, 0, 5'b11111, 3'b011, 1, 64'd3);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd3);
    // mem_busy dominates ex_busy and load_use
    v(1, 5'b00111, 0, 5'b00000, 3'b111, 1, 64'd3);
    v(1, 5'b00111, 0, 5'b00000, 3'b111, 1, 64'd4);
    v(1, 5'b00111, 0, 5'b00000, 3'b111, 1, 64'd5);
    v(1, 5'b00110, 0, 5'b00011, 3'b110, 1, 64'd6);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd7);
    // mem_busy with redirect: redirect held upstream
    v(1, 5'b01001, 0, 5'b00000, 3'b111, 1, 64'd7);
    v(1, 5'b01000, 0, 5'b11111, 3'b001, 1, 64'd8);
    v(1, 5'b00000, 0, 5'b11111, 3'b011, 1, 64'd8);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd8);
    // trap during ex_busy
    v(1, 5'b00010, 0, 5'b00011, 3'b110, 1, 64'd8);
    v(1, 5'b10010, 0, 5'b11111, 3'b000, 1, 64'd9);
    v(1, 5'b00010, 0, 5'b11111, 3'b000, 0, 64'd9);
    v(1, 5'b00010, 0, 5'b11111, 3'b000, 0, 64'd9);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd9);
    // trap preempts REDIR
    v(1, 5'b01000, 0, 5'b11111, 3'b001, 1, 64'd9);
    v(1, 5'b10000, 0, 5'b11111, 3'b000, 1, 64'd9);
    v(1, 5'b00000, 0, 5'b11111, 3'b000, 0, 64'd9);
    v(1, 5'b00000, 0, 5'b11111, 3'b000, 0, 64'd9);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd9);
    // reset aborting TRAP and REDIR
    v(1, 5'b10000, 0, 5'b11111, 3'b000, 1, 64'd9);
    v(0, 5'b00000, 0, 5'b11111, 3'b000, 0, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 0, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd0);
    v(1, 5'b01000, 0, 5'b11111, 3'b001, 1, 64'd0);
    v(0, 5'b00000, 0, 5'b11111, 3'b000, 0, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 0, 64'd0);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, 64'd0);
    // counter saturation
    v(1, 5'b00001, 1, 5'b00000, 3'b111, 1, 64'd0);
    v(1, 5'b00010, 0, 5'b00011, 3'b110, 1, PRELOAD);
    v(1, 5'b00001, 0, 5'b00000, 3'b111, 1, PRELOAD + 64'd1);
    v(1, 5'b00010, 0, 5'b00011, 3'b110, 1, SAT);
    v(1, 5'b00000, 0, 5'b11111, 3'b111, 1, SAT);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (forced) begin
        release dut.stall_cnt_d;
        forced = 1'b0;
      end
      t   = vq[i];
      rst = t.rst;
      {trap, redirect, load_use, ex_busy, mem_busy} = t.in;
      if (t.pre) begin
        force dut.stall_cnt_d = PRELOAD;
        forced = 1'b1;
      end
      e.idx = 8'(i); e.en = t.en; e.vld = t.vld; e.flush = t.flush; e.stall = t.stall;
      sb.push_back(e);
    end
    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
